// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and the bit-period rounding
// function, common to the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: single clock, power-of-two depth,
// pointers wrap modulo depth, count is one bit wider than the pointers.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even if a pop happens on the same edge.
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since the pointers flush it.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit after bit 7.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int BAUD            = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int STOP_BITS       = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_wdata,
    input  logic       i_wvalid,
    output logic       o_wready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_ODD = 1'b0;
`endif

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_q;
    logic [7:0]           shift_q;
    logic                 tx_q;
    logic                 ovf_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    logic [7:0]           f_data;
    logic                 f_full;
    logic                 f_empty;
    logic [FIFO_DEPTH_LOG2:0] f_count;
    logic                 push;
    logic                 pop;
    logic                 bit_end;

    assign push     = i_wvalid && !f_full;
    assign bit_end  = (cnt_q == CNT_LAST);

    // Pop when idle, or at the very end of the last stop bit for back-to-back frames.
    assign pop = !f_empty &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_STOP) && bit_end && (bit_q == STOP_LAST)));

    assign o_wready   = !f_full;
    assign o_tx       = tx_q;
    assign o_busy     = (f_count != '0) || (state_q != ST_IDLE);
    assign o_overflow = ovf_q;

    uart_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (i_wdata),
        .i_pop   (pop),
        .o_data  (f_data),
        .o_full  (f_full),
        .o_empty (f_empty),
        .o_count (f_count)
    );

    // Frame FSM with baud counter, shift register and registered line output.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (i_wvalid && f_full) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (pop) begin
                        shift_q <= f_data;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^f_data ^ PARITY_ODD;
`endif
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            bit_q <= '0;
                            if (pop) begin
                                shift_q <= f_data;
`ifdef UART_TX_PARITY_EN
                                par_q   <= ^f_data ^ PARITY_ODD;
`endif
                                tx_q    <= 1'b0;
                                state_q <= ST_START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms built from frame
// rules, table-driven single frames, corner sequences and a random stream.
module tb_uart_tx;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FL = 10 + NPAR;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic       wvalid = 1'b0;
    logic       wvalid2 = 1'b0;
    logic       wready, tx, busy, ovf;
    logic       wready2, tx2, busy2, ovf2;

    int checks = 0;
    int errors = 0;

    logic       wave_q[$];
    logic       samp_q[$];
    logic [7:0] bq[$];
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    logic       rx_en = 1'b0;
    int         rx_err = 0;

    typedef struct {
        logic [7:0] data;
        logic       lsb;
        logic       msb;
        logic       par;
    } vec_t;
    vec_t tbl[4];

    uart_tx #(
        .CLK_HZ(1_000_000), .BAUD(100_000),
        .FIFO_DEPTH_LOG2(2), .STOP_BITS(1)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_wdata(wdata), .i_wvalid(wvalid),
        .o_wready(wready), .o_tx(tx), .o_busy(busy), .o_overflow(ovf)
    );

    uart_tx #(
        .CLK_HZ(1_000_000), .BAUD(100_000),
        .FIFO_DEPTH_LOG2(2), .STOP_BITS(2)
    ) dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_wdata(wdata), .i_wvalid(wvalid2),
        .o_wready(wready2), .o_tx(tx2), .o_busy(busy2), .o_overflow(ovf2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional even parity, stops.
    function automatic void add_frame(input logic [7:0] d, input int nstop);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (NPAR == 1) bits.push_back(1'($countones(d) % 2));
        for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
        foreach (bits[b])
            for (int k = 0; k < DIV; k++) wave_q.push_back(bits[b]);
    endfunction

    task automatic burst(input int sel);
        @(negedge clk);
        foreach (bq[i]) begin
            wdata = bq[i];
            if (sel != 0) wvalid2 = 1'b1;
            else wvalid = 1'b1;
            @(negedge clk);
        end
        wvalid  = 1'b0;
        wvalid2 = 1'b0;
    endtask

    // Sample k=0 is just after the first push edge E; line must still be idle.
    task automatic expect_wave(input int sel, input string name);
        int   bad;
        int   first;
        logic v;
        logic e;
        bad = 0;
        first = -1;
        samp_q.delete();
        @(negedge clk);
        @(posedge clk);
        for (int k = 0; k <= wave_q.size() + DIV; k++) begin
            @(negedge clk);
            v = (sel != 0) ? tx2 : tx;
            e = (k == 0 || k > wave_q.size()) ? 1'b1 : wave_q[k-1];
            samp_q.push_back(v);
            if (v !== e) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d wrong samples, first at E+%0d, required 0",
                     name, bad, first);
        end
    endtask

    // Behavioural receiver: mid-bit sampling of the line.
    initial begin
        logic [7:0] d;
        logic       p;
        forever begin
            @(negedge clk);
            if (rx_en && tx == 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                if (tx !== 1'b0) rx_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    d[i] = tx;
                end
                if (NPAR == 1) begin
                    repeat (DIV) @(negedge clk);
                    p = tx;
                    if (p !== 1'($countones(d) % 2)) rx_err++;
                end
                repeat (DIV) @(negedge clk);
                if (tx !== 1'b1) rx_err++;
                rx_q.push_back(d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k1, k2, w, bad;
        logic [7:0] b;

        tbl[0] = '{data: 8'hA5, lsb: 1'b1, msb: 1'b1, par: 1'b0};
        tbl[1] = '{data: 8'h01, lsb: 1'b1, msb: 1'b0, par: 1'b1};
        tbl[2] = '{data: 8'h80, lsb: 1'b0, msb: 1'b1, par: 1'b1};
        tbl[3] = '{data: 8'h3C, lsb: 1'b0, msb: 1'b0, par: 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_wready", wready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frames from the table.
        foreach (tbl[i]) begin
            wave_q.delete();
            add_frame(tbl[i].data, 1);
            bq.delete();
            bq.push_back(tbl[i].data);
            fork
                burst(0);
                expect_wave(0, $sformatf("frame_%02h", tbl[i].data));
            join
            chk($sformatf("lsb_%02h", tbl[i].data),
                samp_q[1*DIV + DIV/2 + 1], tbl[i].lsb);
            chk($sformatf("msb_%02h", tbl[i].data),
                samp_q[8*DIV + DIV/2 + 1], tbl[i].msb);
`ifdef UART_TX_PARITY_EN
            chk($sformatf("par_%02h", tbl[i].data),
                samp_q[9*DIV + DIV/2 + 1], tbl[i].par);
`else
            chk($sformatf("stop_%02h", tbl[i].data),
                samp_q[9*DIV + DIV/2 + 1], 1);
`endif
            chk($sformatf("idle_busy_%02h", tbl[i].data), busy, 0);
        end

        // Back-to-back 0x00 then 0xFF.
        wave_q.delete();
        add_frame(8'h00, 1);
        add_frame(8'hFF, 1);
        bq.delete();
        bq.push_back(8'h00);
        bq.push_back(8'hFF);
        fork
            burst(0);
            expect_wave(0, "b2b_wave");
        join
        k1 = -1;
        k2 = -1;
        foreach (samp_q[k]) begin
            if (k1 < 0 && samp_q[k] == 1'b0) k1 = k;
            else if (k1 >= 0 && k2 < 0 && k > 0 &&
                     samp_q[k-1] == 1'b1 && samp_q[k] == 1'b0) k2 = k;
        end
        chk("b2b_spacing", k2 - k1, FL * DIV);

        // Overflow: six bytes offered, ready ignored.
        wave_q.delete();
        bq.delete();
        for (int i = 1; i <= 6; i++) bq.push_back(8'(i));
        for (int i = 1; i <= 5; i++) add_frame(8'(i), 1);
        fork
            begin
                burst(0);
                chk("ovf_wready_low", wready, 0);
                chk("ovf_set", ovf, 1);
            end
            expect_wave(0, "ovf_wave");
        join
        chk("ovf_sticky", ovf, 1);
        chk("ovf_wready_back", wready, 1);

        // Reset during a start bit with a byte still queued.
        bq.delete();
        bq.push_back(8'hA5);
        bq.push_back(8'h5A);
        burst(0);
        repeat (3) @(negedge clk);
        chk("pre_rst_start_bit", tx, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_wready", wready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 3 * FL * DIV; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 0);

        // Two stop bits on the second instance.
        wave_q.delete();
        add_frame(8'h3C, 2);
        bq.delete();
        bq.push_back(8'h3C);
        fork
            burst(1);
            expect_wave(1, "stop2_wave");
        join
        chk("stop2_busy", busy2, 0);
        chk("stop2_ovf", ovf2, 0);

        // Random stream through the receiver model.
        rx_q.delete();
        sent_q.delete();
        rx_en = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = 0;
            while (!wready && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (!wready) chk("rand_wready_wait", wready, 1);
            b = 8'($urandom);
            wdata = b;
            wvalid = 1'b1;
            sent_q.push_back(b);
            @(negedge clk);
            wvalid = 1'b0;
        end
        w = 0;
        while (busy && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk("rand_drain", busy, 0);
        repeat (2 * DIV) @(negedge clk);
        rx_en = 1'b0;
        chk("rand_count", rx_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
            chk($sformatf("rand_byte_%0d", i), rx_q[i], sent_q[i]);
        chk("rand_framing", rx_err, 0);
        chk("rand_no_ovf", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
